sram512x8_wb_ctrl: RTL and testbench

- Initiator for the 512x8 single-port SRAM macro wrapper. Sequences 32-bit Wishbone classic word accesses into four byte accesses on the SRAM port.
- Sits between the SoC data bus and one 512x8 SRAM instance, giving the CPU a 128-word scratch memory.
- SRAM port contract: CEN active-low, WEN active-high, registered read data valid one clock after the address cycle.

---
 rtl/sram512x8_wb_ctrl.sv | 132 +++++++++++++
 tb/tb_sram512x8_wb_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram512x8_wb_ctrl.sv
// Wishbone classic word initiator for a 512x8 single-port SRAM: one 32-bit access becomes four byte accesses.
// Optional macro SRAM_CTRL_SKIP_EN: write accesses visit only the selected byte lanes.
module sram512x8_wb_ctrl #(
  parameter int WORD_ADR_W = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [WORD_ADR_W+1:0] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  ram_cen_o,
  output logic                  ram_wen_o,
  output logic [WORD_ADR_W+1:0] ram_adr_o,
  output logic [7:0]            ram_dat_o,
  input  logic [7:0]            ram_dat_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, ACK} state_t;

  state_t                state, state_n;
  logic [1:0]            cnt, cnt_n;
  logic [WORD_ADR_W-1:0] word_adr;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [1:0]            rd_lane;
  logic                  unused_adr_lsbs;

  assign unused_adr_lsbs = ^wb_adr_i[1:0];

`ifdef SRAM_CTRL_SKIP_EN
  logic [2:0] lane;

  // Lowest set lane at or above 'from'; bit 2 of the result flags "none left".
  function automatic logic [2:0] next_lane(input logic [3:0] sel, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--)
      if (sel[i] && (3'(i) >= from)) r = {1'b0, 2'(i)};
    return r;
  endfunction
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
`ifdef SRAM_CTRL_SKIP_EN
    lane    = 3'b100;
`endif
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_n = ACCESS;
          cnt_n   = 2'd0;
`ifdef SRAM_CTRL_SKIP_EN
          if (wb_we_i) begin
            lane = next_lane(wb_sel_i, 3'd0);
            if (lane[2]) state_n = ACK;
            else         cnt_n   = lane[1:0];
          end
`endif
        end
      end
      ACCESS: begin
        if (!wb_cyc_i) begin
          state_n = IDLE;
        end else
`ifdef SRAM_CTRL_SKIP_EN
        if (we_q) begin
          lane = next_lane(sel_q, {1'b0, cnt} + 3'd1);
          if (lane[2]) state_n = ACK;
          else         cnt_n   = lane[1:0];
        end else
`endif
        begin
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) state_n = we_q ? ACK : DRAIN;
        end
      end
      DRAIN:   state_n = wb_cyc_i ? ACK : IDLE;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wb_ack_o  = (state == ACK);
    ram_adr_o = {word_adr, cnt};
    ram_dat_o = wdata_q[{cnt, 3'b000} +: 8];
    ram_cen_o = 1'b1;
    ram_wen_o = 1'b0;
    if (state == ACCESS) begin
      if (we_q) begin
        ram_cen_o = ~sel_q[cnt];
        ram_wen_o = sel_q[cnt];
      end else begin
        ram_cen_o = 1'b0;
      end
    end
    // The macro's read data lags the address cycle by one clock.
    rd_lane = (state == DRAIN) ? 2'd3 : cnt - 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      word_adr <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      wdata_q  <= 32'd0;
      wb_dat_o <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && wb_cyc_i && wb_stb_i) begin
        word_adr <= wb_adr_i[WORD_ADR_W+1:2];
        we_q     <= wb_we_i;
        sel_q    <= wb_sel_i;
        wdata_q  <= wb_dat_i;
      end
      if ((state == ACCESS && !we_q && cnt != 2'd0) || state == DRAIN)
        wb_dat_o[{rd_lane, 3'b000} +: 8] <= ram_dat_i;
    end
  end

endmodule

// File: tb/tb_sram512x8_wb_ctrl.sv
// Scoreboard bench for sram512x8_wb_ctrl with a behavioural 512x8 SRAM (registered read data).
module tb_sram512x8_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [8:0]  wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_wdat, wb_rdat;
  logic        wb_ack;
  logic        ram_cen, ram_wen;
  logic [8:0]  ram_adr;
  logic [7:0]  ram_wdat;
  logic [7:0]  ram_rdata = 8'd0;

  logic [7:0]  mem [0:511];
  int          edge_cnt = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;

`ifdef SRAM_CTRL_SKIP_EN
  localparam int LAT_W4 = 5;
  localparam int LAT_W2 = 3;
`else
  localparam int LAT_W4 = 5;
  localparam int LAT_W2 = 5;
`endif
  localparam int LAT_RD = 6;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          lat;
    int          start;
  } rsp_t;

  typedef struct {
    logic [8:0] adr;
    logic       wen;
    logic [7:0] dat;
  } acc_t;

  rsp_t rsp_q[$];
  acc_t acc_q[$];

  always #5 clk = ~clk;

  sram512x8_wb_ctrl #(.WORD_ADR_W(7)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb_cyc_i  (wb_cyc),
    .wb_stb_i  (wb_stb),
    .wb_we_i   (wb_we),
    .wb_adr_i  (wb_adr),
    .wb_sel_i  (wb_sel),
    .wb_dat_i  (wb_wdat),
    .wb_dat_o  (wb_rdat),
    .wb_ack_o  (wb_ack),
    .ram_cen_o (ram_cen),
    .ram_wen_o (ram_wen),
    .ram_adr_o (ram_adr),
    .ram_dat_o (ram_wdat),
    .ram_dat_i (ram_rdata)
  );

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'hA5;
  end

  // SRAM model: CEN active-low, WEN active-high, read data registered.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (ram_cen === 1'b0) begin
      if (ram_wen === 1'b1) mem[ram_adr] <= ram_wdat;
      else                  ram_rdata    <= mem[ram_adr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Response monitor: every ack must match the oldest outstanding transaction.
  always @(negedge clk) begin
    rsp_t r;
    if (wb_ack === 1'b1) begin
      if (rsp_q.size() == 0) begin
        checkOutput("unexpected_ack", 32'd1, 32'd0);
      end else begin
        r = rsp_q.pop_front();
        checkOutput("ack_latency", edge_cnt - r.start + 1, r.lat);
        if (r.is_read) checkOutput("read_data", wb_rdat, r.data);
      end
    end
  end

  // SRAM port monitor: every enabled cycle must match the next expected byte access.
  always @(negedge clk) begin
    acc_t a;
    if (ram_cen === 1'b0) begin
      if (acc_q.size() == 0) begin
        checkOutput("unexpected_ram_access", {23'd0, ram_adr}, 32'hFFFF_FFFF);
      end else begin
        a = acc_q.pop_front();
        checkOutput("ram_adr", {23'd0, ram_adr}, {23'd0, a.adr});
        checkOutput("ram_wen", {31'd0, ram_wen}, {31'd0, a.wen});
        if (a.wen) checkOutput("ram_wdat", {24'd0, ram_wdat}, {24'd0, a.dat});
      end
    end else if (ram_wen !== 1'b0) begin
      checkOutput("wen_while_disabled", {31'd0, ram_wen}, 32'd0);
    end
  end

  task automatic applyStimulus(input logic we, input logic [8:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, input logic [31:0] exp_rd, input int exp_lat);
    rsp_t r;
    acc_t a;
    int   k;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!we || sel[i]) begin
        a.adr = {adr[8:2], i[1:0]};
        a.wen = we;
        a.dat = dat[8*i +: 8];
        acc_q.push_back(a);
      end
    end
    r.is_read = !we;
    r.data    = exp_rd;
    r.lat     = exp_lat;
    r.start   = edge_cnt + 1;
    rsp_q.push_back(r);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr;  wb_sel = sel;  wb_wdat = dat;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (wb_ack !== 1'b1 && k < 20);
    if (wb_ack !== 1'b1) begin
      checkOutput("ack_timeout", 32'd0, 32'd1);
      rsp_q.delete();
      acc_q.delete();
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic pushAccess(input logic [8:0] adr, input logic wen, input logic [7:0] dat);
    acc_t a;
    a.adr = adr; a.wen = wen; a.dat = dat;
    acc_q.push_back(a);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = 9'd0; wb_sel = 4'd0; wb_wdat = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ack",      {31'd0, wb_ack},   32'd0);
    checkOutput("rst_wb_dat",   wb_rdat,           32'd0);
    checkOutput("rst_ram_cen",  {31'd0, ram_cen},  32'd1);
    checkOutput("rst_ram_wen",  {31'd0, ram_wen},  32'd0);
    checkOutput("rst_ram_adr",  {23'd0, ram_adr},  32'd0);
    checkOutput("rst_ram_wdat", {24'd0, ram_wdat}, 32'd0);
    rst = 1'b0;

    $display("[TB] word write / read at 0x010");
    applyStimulus(1'b1, 9'h010, 4'hF, 32'hDEADBEEF, 32'd0, LAT_W4);
    applyStimulus(1'b0, 9'h010, 4'hF, 32'd0, 32'hDEADBEEF, LAT_RD);

    $display("[TB] partial write at 0x020");
    applyStimulus(1'b1, 9'h020, 4'hF, 32'h11223344, 32'd0, LAT_W4);
    applyStimulus(1'b1, 9'h020, 4'b0101, 32'hAABBCCDD, 32'd0, LAT_W2);
    applyStimulus(1'b0, 9'h020, 4'h0, 32'd0, 32'h11BB33DD, LAT_RD);

    $display("[TB] top boundary at 0x1FC");
    applyStimulus(1'b1, 9'h1FC, 4'hF, 32'hCAFEF00D, 32'd0, LAT_W4);
    applyStimulus(1'b0, 9'h1FC, 4'hF, 32'd0, 32'hCAFEF00D, LAT_RD);

    $display("[TB] abort write at 0x040");
    @(negedge clk);
    pushAccess(9'h040, 1'b1, 8'h04);
    pushAccess(9'h041, 1'b1, 8'h03);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 9'h040; wb_sel = 4'hF; wb_wdat = 32'h01020304;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    checkOutput("abort_ram_cen", {31'd0, ram_cen}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("abort_byte0", {24'd0, mem[9'h040]}, 32'h04);
    checkOutput("abort_byte2", {24'd0, mem[9'h042]}, 32'hA5);

    $display("[TB] async reset mid-read");
    @(negedge clk);
    pushAccess(9'h010, 1'b0, 8'h00);
    pushAccess(9'h011, 1'b0, 8'h00);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
    wb_adr = 9'h010; wb_sel = 4'hF; wb_wdat = 32'h5555AAAA;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_ack",      {31'd0, wb_ack},   32'd0);
    checkOutput("arst_wb_dat",   wb_rdat,           32'd0);
    checkOutput("arst_ram_cen",  {31'd0, ram_cen},  32'd1);
    checkOutput("arst_ram_wen",  {31'd0, ram_wen},  32'd0);
    checkOutput("arst_ram_adr",  {23'd0, ram_adr},  32'd0);
    checkOutput("arst_ram_wdat", {24'd0, ram_wdat}, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 9'h010, 4'hF, 32'd0, 32'hDEADBEEF, LAT_RD);

`ifdef SRAM_CTRL_SKIP_EN
    $display("[TB] lane skipping writes");
    applyStimulus(1'b1, 9'h030, 4'b1000, 32'h77665544, 32'd0, 2);
    applyStimulus(1'b1, 9'h034, 4'b0000, 32'h12345678, 32'd0, 1);
    applyStimulus(1'b0, 9'h030, 4'hF, 32'd0, 32'h77A5A5A5, LAT_RD);
    applyStimulus(1'b0, 9'h034, 4'hF, 32'd0, 32'hA5A5A5A5, LAT_RD);
`endif

    repeat (5) @(negedge clk);
    checkOutput("rsp_queue_empty", rsp_q.size(), 32'd0);
    checkOutput("acc_queue_empty", acc_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
